// File: rtl/aspiradora_cmd_gen_if.sv
// Command bus between the button/sensor front end and the vacuum FSM:
// raw inputs and state feedback in, one-hot switch commands and fault out.
interface aspiradora_cmd_gen_if;
    logic       btn_power;
    logic       btn_clean;
    logic       bump;
    logic [1:0] state_in;
    logic       power_off;
    logic       on;
    logic       cleaning;
    logic       evading;
    logic       fault;

    modport master (
        output btn_power, btn_clean, bump, state_in,
        input  power_off, on, cleaning, evading, fault
    );

    modport slave (
        input  btn_power, btn_clean, bump, state_in,
        output power_off, on, cleaning, evading, fault
    );
endinterface

// File: rtl/aspiradora_cmd_gen.sv
// Debounced command generator for the vacuum FSM: turns raw buttons and the
// bump sensor into one-hot level commands and watches the FSM's state echo.
module aspiradora_cmd_gen #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned EVADE_CYCLES = 16,
    parameter int unsigned ACK_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    aspiradora_cmd_gen_if.slave   bus
);
    localparam int unsigned NIN = 3;
    localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW  = $clog2(EVADE_CYCLES + 1);
    localparam int unsigned AW  = $clog2(ACK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_CLEAN = 2'b10,
        ST_EVADE = 2'b11
    } state_t;

    logic [NIN-1:0] raw;
    logic [NIN-1:0] sync1_q, sync2_q;
    logic [NIN-1:0] deb_q, deb_prev_q;
    logic [NIN-1:0] armed_q;
    logic [1:0]     vld_q;
    logic [DCW-1:0] cnt_q [NIN];
    logic [NIN-1:0] evt;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] mis_q, mis_d;
    logic          fault_q, fault_d;

    assign raw = {bus.bump, bus.btn_clean, bus.btn_power};

    // Synchronize, debounce and arm each input. An input is armed only once it
    // has been seen low after reset, so a button held through reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            armed_q    <= '0;
            vld_q      <= '0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            vld_q      <= {vld_q[0], 1'b1};
            for (int i = 0; i < NIN; i++) begin
                armed_q[i] <= armed_q[i] | (vld_q[1] & ~sync2_q[i]);
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    assign evt = deb_q & ~deb_prev_q & armed_q;

    // State register plus registered one-hot commands derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            timer_q       <= '0;
            mis_q         <= '0;
            fault_q       <= 1'b0;
            bus.power_off <= 1'b1;
            bus.on        <= 1'b0;
            bus.cleaning  <= 1'b0;
            bus.evading   <= 1'b0;
            bus.fault     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mis_q         <= mis_d;
            fault_q       <= fault_d;
            bus.power_off <= (state_d == ST_OFF);
            bus.on        <= (state_d == ST_ON);
            bus.cleaning  <= (state_d == ST_CLEAN);
            bus.evading   <= (state_d == ST_EVADE);
            bus.fault     <= fault_d;
        end
    end

    // Next-state: power beats everything; a fault pins the FSM to OFF.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mis_d   = mis_q;
        fault_d = fault_q;

        if (fault_q) begin
            state_d = ST_OFF;
        end else if (evt[0]) begin
            state_d = (state_q == ST_OFF) ? ST_ON : ST_OFF;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (evt[1]) state_d = ST_CLEAN;
                end
                ST_CLEAN: begin
                    if (evt[2]) begin
                        state_d = ST_EVADE;
                        timer_d = TW'(EVADE_CYCLES);
                    end
                end
                ST_EVADE: begin
                    if (timer_q <= TW'(1)) begin
                        state_d = ST_CLEAN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end

        if ((state_d != state_q) || (bus.state_in == state_q)) begin
            mis_d = '0;
        end else if (mis_q != AW'(ACK_CYCLES)) begin
            mis_d = mis_q + AW'(1);
        end

        if (mis_d == AW'(ACK_CYCLES)) fault_d = 1'b1;

        if (fault_d) begin
            state_d = ST_OFF;
            timer_d = '0;
        end
    end
endmodule

// File: doc/aspiradora_cmd_gen.md
ASPIRADORA_CMD_GEN -- requirements
Module: aspiradora_cmd_gen

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, consecutive stable cycles required to accept a new debounced input level (>=1).
REQ-002 SHALL have parameter EVADE_CYCLES, default 16, clock cycles spent in EVADE before returning to CLEAN (>=1).
REQ-003 SHALL have parameter ACK_CYCLES, default 8, consecutive mismatch cycles before fault is raised (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port btn_power  input  1  raw asynchronous power push button.
REQ-007 SHALL have port btn_clean  input  1  raw asynchronous start-cleaning push button.
REQ-008 SHALL have port bump  input  1  raw asynchronous obstacle sensor.
REQ-009 SHALL have port state_in  input  2  state code reported back by the vacuum FSM (00 OFF, 01 ON, 10 CLEANING, 11 EVADING).
REQ-010 SHALL have ports power_off, on, cleaning, evading  output  1 each  registered level commands to the vacuum FSM switch inputs.
REQ-011 SHALL have port fault  output  1  sticky registered flag: FSM failed to follow command.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer, then a debouncer whose output takes a new level only after the synchronized value holds that level for DEB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-013 Only rising edges of debounced signals SHALL be events; one edge yields exactly one event.
REQ-014 Internal command FSM SHALL have states OFF, ON, CLEAN, EVADE with codes 00, 01, 10, 11.
REQ-015 Transitions: OFF + power event -> ON; ON + clean event -> CLEAN; CLEAN + bump event -> EVADE (timer loaded EVADE_CYCLES); EVADE with timer reaching 0 -> CLEAN; ON/CLEAN/EVADE + power event -> OFF; all other cases hold.
REQ-016 Power event SHALL have priority over every simultaneous event or timer expiry.
REQ-017 Bump events in EVADE SHALL be ignored (timer not reloaded); bump events outside CLEAN SHALL be ignored.
REQ-018 Outputs SHALL be one-hot of the current state (OFF->power_off, ON->on, CLEAN->cleaning, EVADE->evading), never zero-hot, never multi-hot.
REQ-019 Command outputs SHALL change exactly 2+DEB_CYCLES+1 clock edges after a clean raw input transition (7 with defaults).
REQ-020 EVADE SHALL last exactly EVADE_CYCLES cycles of evading=1 when no power event occurs.
REQ-021 Mismatch counter SHALL increment each cycle state_in differs from current state code, clear on match or on any state transition, saturate at ACK_CYCLES.
REQ-022 fault SHALL rise the cycle the mismatch counter reaches ACK_CYCLES and stay 1 until reset.
REQ-023 While fault=1 the command FSM SHALL be forced to OFF and ignore all events.

Reset
REQ-024 On rst=1 at a clock edge: state OFF, power_off=1, on=0, cleaning=0, evading=0, fault=0, all synchronizers, debouncers (level 0), counters, timer cleared.
REQ-025 Reset SHALL take priority over every event, including mid-EVADE and with fault set; a button held high across reset release SHALL NOT produce an event until released and pressed again.

Verification
REQ-026 Reset, then btn_power 0->1 held, state_in mirroring -> on=1, power_off=0 exactly 7 edges after the change.
REQ-027 From ON, btn_clean press, then bump press -> cleaning=1, then evading=1 for exactly 16 cycles, then cleaning=1 again.
REQ-028 btn_power pulse of 3 cycles (< DEB_CYCLES) -> no output change; 2-cycle low glitch inside a 10-cycle press -> single event only.
REQ-029 In EVADE, power and timer expiry debounce-aligned to same cycle -> power_off=1, not cleaning.
REQ-030 state_in held 00 after commanding ON -> fault=1 after 8 mismatch cycles, power_off=1, further presses ignored until rst.
REQ-031 rst asserted mid-EVADE with btn_power held -> power_off=1, fault=0 next cycle; no event until btn_power released and re-pressed.
